// File: rtl/fb_pkg.sv
// Shared screen geometry, coordinate widths and scheduler types for the
// framebuffer write scheduler.
package fb_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_WAIT = 2'd1,
    CLEAR      = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           color;
  } fb_pixel_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a
// registered pointer, which moves past the granted index on advance.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  input  logic                 advance_i,
  input  logic [$clog2(N)-1:0] adv_idx_i,
  output logic [N-1:0]         gnt_c_o,
  output logic [$clog2(N)-1:0] gnt_idx_c_o
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand_c;
  logic             found_c;

  // First requester at or after the pointer, with wrap-around
  always_comb begin
    gnt_c_o     = '0;
    gnt_idx_c_o = '0;
    found_c     = 1'b0;
    cand_c      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_c = IDX_W'((32'(ptr_q) + k) % N);
      if (!found_c && req_i[cand_c]) begin
        found_c         = 1'b1;
        gnt_c_o[cand_c] = 1'b1;
        gnt_idx_c_o     = cand_c;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (32'(adv_idx_i) == N - 1) ? '0 : IDX_W'(adv_idx_i + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Shares the framebuffer write port among NUM_REQ drawing engines and runs a
// frame-aligned full-screen clear that pre-empts all requesters.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = SCREEN_W,
  parameter int unsigned HEIGHT  = SCREEN_H
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       clear_req,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*X_W-1:0]     req_x,
  input  logic [NUM_REQ*Y_W-1:0]     req_y,
  input  logic [NUM_REQ-1:0]         req_color,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [X_W-1:0]             fb_x,
  output logic [Y_W-1:0]             fb_y,
  output logic                       fb_pixel_color,
  output logic                       fb_pixel_write,
  output logic                       clear_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned    IDX_W  = $clog2(NUM_REQ);
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  sched_state_t     state_q, state_d;
  fb_pixel_t        fb_q, fb_d, sel_c;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] gid_q, gid_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;

  logic [NUM_REQ-1:0] arb_req_c, gnt_c;
  logic [IDX_W-1:0]   gnt_idx_c;
  logic               xfer_c, in_range_c, last_px_c;

  // Requesters only compete while idle; ready is forced low during reset
  assign arb_req_c = (state_q == IDLE) ? req_valid : '0;
  assign req_ready = gnt_c & {NUM_REQ{reset}};
  assign xfer_c    = |req_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i      (clk),
    .rst_ni     (reset),
    .req_i      (arb_req_c),
    .advance_i  (xfer_c),
    .adv_idx_i  (gnt_idx_c),
    .gnt_c_o    (gnt_c),
    .gnt_idx_c_o(gnt_idx_c)
  );

  always_comb begin
    sel_c       = '0;
    sel_c.x     = req_x[X_W*32'(gnt_idx_c) +: X_W];
    sel_c.y     = req_y[Y_W*32'(gnt_idx_c) +: Y_W];
    sel_c.color = req_color[gnt_idx_c];
  end

  assign in_range_c = (32'(sel_c.x) < WIDTH) && (32'(sel_c.y) < HEIGHT);
  // While clearing, fb_q holds the pixel being written this cycle
  assign last_px_c  = (fb_q.x == X_LAST) && (fb_q.y == Y_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (clear_req)   state_d = CLEAR_WAIT;
      CLEAR_WAIT: if (frame_start) state_d = CLEAR;
      CLEAR:      if (last_px_c)   state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    fb_d    = fb_q;
    write_d = 1'b0;
    busy_d  = (state_d != IDLE);
    gid_d   = gid_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (state_d == CLEAR) begin
      fb_d    = '{x: cx_q, y: cy_q, color: 1'b0};
      write_d = 1'b1;
      if (cx_q == X_LAST) begin
        cx_d = '0;
        cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end else if (xfer_c) begin
      gid_d = gnt_idx_c;
      if (in_range_c) begin
        fb_d    = sel_c;
        write_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_q    <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      gid_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      fb_q    <= fb_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  assign fb_x           = fb_q.x;
  assign fb_y           = fb_q.y;
  assign fb_pixel_color = fb_q.color;
  assign fb_pixel_write = write_q;
  assign clear_busy     = busy_q;
  assign grant_id       = gid_q;

endmodule
